k_fifo_2deep_ctrl: RTL and testbench

K_FIFO_2DEEP_CTRL -- requirements
Module: k_fifo_2deep_ctrl

---
 rtl/k_fifo_2deep_ctrl_if.sv | 22 ++
 rtl/k_fifo_2deep_ctrl.sv | 90 +++++++++
 tb/tb_k_fifo_2deep_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/k_fifo_2deep_ctrl_if.sv
// Valid/ready handshake bundle for the 2-deep FIFO controller.
// slave is the FIFO side; master is the upstream/downstream side.
interface k_fifo_2deep_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );
endinterface

// File: rtl/k_fifo_2deep_ctrl.sv
// Control for a 2-entry FIFO built around an external dual-port RAM.
// The RAM read is combinational, so the head word sits on q while out_valid.
module k_fifo_2deep_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  k_fifo_2deep_ctrl_if.slave hs,
  output logic       wen,
  output logic       waddr,
  output logic       raddr,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   wr_ptr;
  logic   rd_ptr;
  logic   wr_nx;
  logic   rd_nx;
  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;

  // No write-through when FULL: it would clobber the unread head.
  assign in_ready  = rst_n & ~flush & (state != FULL);
  assign out_valid = rst_n & ~flush & (state != EMPTY);
  assign push      = hs.in_valid & in_ready;
  assign pop       = out_valid & hs.out_ready;

  assign hs.in_ready  = in_ready;
  assign hs.out_valid = out_valid;

  assign wen   = push;
  assign waddr = wr_ptr;
  assign raddr = rd_ptr;
  assign count = state;
  assign full  = (state == FULL);
  assign empty = (state == EMPTY);

  always_comb begin
    state_nx = state;
    wr_nx    = wr_ptr ^ push;
    rd_nx    = rd_ptr ^ pop;
    if (flush) begin
      state_nx = EMPTY;
      wr_nx    = 1'b0;
      rd_nx    = 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) state_nx = ONE;
        end
        ONE: begin
          if (push && !pop) state_nx = FULL;
          else if (pop && !push) state_nx = EMPTY;
        end
        FULL: begin
          if (pop) state_nx = ONE;
        end
        default: begin
          state_nx = EMPTY;
          wr_nx    = 1'b0;
          rd_nx    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
    end
  end

endmodule

// File: tb/tb_k_fifo_2deep_ctrl.sv
// Bench for k_fifo_2deep_ctrl: directed scenarios then random traffic
// against a queue-based FIFO model, with a 2-word RAM attached.
module tb_k_fifo_2deep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wen;
  logic       waddr;
  logic       raddr;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic [7:0] d;
  logic [7:0] q;
  logic [7:0] mem [2];

  int n_cmp;
  int n_bad;

  logic [7:0] mq [$];
  bit         m_wp;
  bit         m_rp;

  k_fifo_2deep_ctrl_if hs ();

  k_fifo_2deep_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .hs    (hs),
    .wen   (wen),
    .waddr (waddr),
    .raddr (raddr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen) mem[waddr] <= d;
  end
  assign q = mem[raddr];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(
    input logic       iv,
    input logic       ordy,
    input logic [7:0] dv,
    input logic       rn,
    input logic       fl
  );
    int  sz;
    bit  exp_ir;
    bit  exp_ov;
    bit  push;
    bit  pop;
    @(negedge clk);
    rst_n        = rn;
    flush        = fl;
    hs.in_valid  = iv;
    hs.out_ready = ordy;
    d            = dv;
    #1;
    sz     = mq.size();
    exp_ir = rn && !fl && (sz < 2);
    exp_ov = rn && !fl && (sz > 0);
    push   = iv && exp_ir;
    pop    = ordy && exp_ov;
    check("in_ready", int'(hs.in_ready), int'(exp_ir));
    check("out_valid", int'(hs.out_valid), int'(exp_ov));
    check("wen", int'(wen), int'(push));
    check("count", int'(count), sz);
    check("full", int'(full), int'(sz == 2));
    check("empty", int'(empty), int'(sz == 0));
    check("waddr", int'(waddr), int'(m_wp));
    check("raddr", int'(raddr), int'(m_rp));
    check("ptr_inv", int'(waddr ^ raddr), int'(sz == 1));
    if (exp_ov) check("q", int'(q), int'(mq[0]));
    @(posedge clk);
    if (!rn || fl) begin
      mq.delete();
      m_wp = 1'b0;
      m_rp = 1'b0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_rp = ~m_rp;
      end
      if (push) begin
        mq.push_back(dv);
        m_wp = ~m_wp;
      end
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    m_wp         = 1'b0;
    m_rp         = 1'b0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    d            = 8'h00;

    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // single push, visible next cycle
    step(1, 0, 8'hA5, 1, 0);
    #1;
    check("a5_count", int'(count), 1);
    check("a5_ov", int'(hs.out_valid), 1);
    check("a5_raddr", int'(raddr), 0);
    check("a5_q", int'(q), 8'hA5);
    step(0, 1, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // fill, blocked third write, drain in order
    step(1, 0, 8'h11, 1, 0);
    step(1, 0, 8'h22, 1, 0);
    step(1, 0, 8'h33, 1, 0);
    #1;
    check("full_flag", int'(full), 1);
    step(0, 1, 8'h00, 1, 0);
    step(0, 1, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // streaming through ONE
    step(1, 0, 8'h00, 1, 0);
    for (int i = 1; i <= 6; i++) step(1, 1, 8'(i), 1, 0);
    step(0, 1, 8'h00, 1, 0);

    // flush from FULL beats a push
    step(1, 0, 8'h11, 1, 0);
    step(1, 0, 8'h22, 1, 0);
    step(1, 0, 8'h44, 1, 1);
    #1;
    check("flush_count", int'(count), 0);
    check("flush_waddr", int'(waddr), 0);
    check("flush_raddr", int'(raddr), 0);

    // reset while ONE
    step(1, 0, 8'h55, 1, 0);
    step(1, 0, 8'h66, 0, 0);
    step(1, 0, 8'h77, 1, 0);
    step(0, 1, 8'h00, 1, 0);

    for (int i = 0; i < 10000; i++) begin
      step(
        1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)),
        8'($urandom),
        ($urandom_range(0, 199) != 0),
        ($urandom_range(0, 49) == 0)
      );
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
